// File: rtl/radar_timing_pkg.sv
// Shared state type, default timing (100 MHz clock, 10 us LFM pulse) and width helper
// for the radar pulse/CPI timing controller.
package radar_timing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_PRF_N      = 10;
  localparam int unsigned DEF_PRI_CYCLES = 2000;
  localparam int unsigned DEF_TX_CYCLES  = 1000;
  localparam int unsigned DEF_RX_START   = 1000;
  localparam int unsigned DEF_RX_LEN     = 900;

  // Index width that stays at least one bit wide when only a single value exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pri_counter.sv
// Wrapping modulo-PRI_CYCLES counter with wrap strobe and synchronous clear.
// nxt_o presents the value the counter takes on the coming edge.
module pri_counter
  import radar_timing_pkg::*;
#(
  parameter int unsigned PRI_CYCLES = DEF_PRI_CYCLES,
  parameter int unsigned CW         = idx_width(PRI_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] nxt_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] LAST = CW'(PRI_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nxt_o = cnt_d;

endmodule

// File: rtl/radar_timing_ctrl.sv
// Pulse/CPI timing controller: sequences PRF_N PRIs with tx enable, rx gate and framing flags.
// Define RADAR_TIMING_CONT_EN for continuous back-to-back CPIs until stop.
module radar_timing_ctrl
  import radar_timing_pkg::*;
#(
  parameter int unsigned PRF_N      = DEF_PRF_N,
  parameter int unsigned PRI_CYCLES = DEF_PRI_CYCLES,
  parameter int unsigned TX_CYCLES  = DEF_TX_CYCLES,
  parameter int unsigned RX_START   = DEF_RX_START,
  parameter int unsigned RX_LEN     = DEF_RX_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  output logic                           busy,
  output logic                           tx_en,
  output logic                           rx_gate,
  output logic                           rx_first,
  output logic                           rx_last,
  output logic [idx_width(PRF_N)-1:0]    pulse_idx,
  output logic                           cpi_start,
  output logic                           cpi_done,
  output logic                           aborted
);

  localparam int unsigned PW = idx_width(PRF_N);
  localparam int unsigned CW = idx_width(PRI_CYCLES);
  localparam logic [PW-1:0] LAST_PULSE = PW'(PRF_N - 1);

  if (PRF_N < 1) begin : g_chk_prf
    $error("radar_timing_ctrl: PRF_N must be at least 1");
  end
  if (RX_LEN < 1) begin : g_chk_rxlen
    $error("radar_timing_ctrl: RX_LEN must be at least 1");
  end
  if (RX_START < TX_CYCLES) begin : g_chk_rxstart
    $error("radar_timing_ctrl: RX_START must not precede the end of the tx window");
  end
  if (RX_START + RX_LEN > PRI_CYCLES) begin : g_chk_rxend
    $error("radar_timing_ctrl: rx window must fit inside the PRI");
  end

  state_e        state_q, state_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          stop_q, stop_d;
  logic          abort_q, abort_d;
  logic          cpi_start_d;
  logic [CW-1:0] cnt_nxt;
  logic          wrap;
  logic [31:0]   cnt_ext;
  logic          run_d;

  logic busy_q, tx_en_q, rx_gate_q, rx_first_q, rx_last_q;
  logic cpi_start_q, cpi_done_q, aborted_q;

  // Counter is held at zero outside RUN so every PRI starts from offset 0.
  pri_counter #(
    .PRI_CYCLES(PRI_CYCLES),
    .CW        (CW)
  ) u_pri_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != RUN),
    .en_i  (state_q == RUN),
    .nxt_o (cnt_nxt),
    .wrap_o(wrap)
  );

  always_comb begin
    state_d     = state_q;
    pulse_d     = pulse_q;
    stop_d      = stop_q;
    abort_d     = abort_q;
    cpi_start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          pulse_d     = '0;
          stop_d      = 1'b0;
          abort_d     = 1'b0;
          cpi_start_d = 1'b1;
        end
      end
      RUN: begin
        stop_d = stop_q || stop;
        // A pending stop (including one arriving on the wrap cycle) beats normal completion.
        if (wrap) begin
          if (stop_q || stop) begin
            state_d = DONE;
            abort_d = 1'b1;
            stop_d  = 1'b0;
            pulse_d = '0;
          end else if (pulse_q == LAST_PULSE) begin
            state_d = DONE;
            abort_d = 1'b0;
            pulse_d = '0;
          end else begin
            pulse_d = pulse_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        stop_d  = 1'b0;
`ifdef RADAR_TIMING_CONT_EN
        if (!abort_q) begin
          state_d     = RUN;
          pulse_d     = '0;
          cpi_start_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign run_d   = (state_d == RUN);
  assign cnt_ext = 32'(cnt_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pulse_q     <= '0;
      stop_q      <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      tx_en_q     <= 1'b0;
      rx_gate_q   <= 1'b0;
      rx_first_q  <= 1'b0;
      rx_last_q   <= 1'b0;
      cpi_start_q <= 1'b0;
      cpi_done_q  <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      stop_q      <= stop_d;
      abort_q     <= abort_d;
      busy_q      <= (state_d != IDLE);
      tx_en_q     <= run_d && (cnt_ext < TX_CYCLES);
      rx_gate_q   <= run_d && (cnt_ext >= RX_START) && (cnt_ext < RX_START + RX_LEN);
      rx_first_q  <= run_d && (cnt_ext == RX_START);
      rx_last_q   <= run_d && (cnt_ext == RX_START + RX_LEN - 1);
      cpi_start_q <= cpi_start_d;
      cpi_done_q  <= (state_d == DONE) && !abort_d;
      aborted_q   <= (state_d == DONE) && abort_d;
    end
  end

  assign busy      = busy_q;
  assign tx_en     = tx_en_q;
  assign rx_gate   = rx_gate_q;
  assign rx_first  = rx_first_q;
  assign rx_last   = rx_last_q;
  assign pulse_idx = pulse_q;
  assign cpi_start = cpi_start_q;
  assign cpi_done  = cpi_done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_radar_timing_ctrl.sv
// Self-checking bench for radar_timing_ctrl: table-driven CPI/abort vectors, reset mid-CPI,
// and a second single-pulse instance with a one-sample rx window.
module tb_radar_timing_ctrl;

  // Output bit order: busy tx_en rx_gate rx_first rx_last cpi_start cpi_done aborted
  typedef struct {
    int       cyc;
    bit       st;
    bit       sp;
    logic [7:0] exp;
    bit       idxValid;
    int       idx;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start, stop, start1;

  logic       busy, txEn, rxGate, rxFirst, rxLast, cpiStart, cpiDone, aborted;
  logic [1:0] pulseIdx;
  logic       busy1, txEn1, rxGate1, rxFirst1, rxLast1, cpiStart1, cpiDone1, aborted1;
  logic [0:0] pulseIdx1;
  logic [7:0] obs, obs1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  radar_timing_ctrl #(
    .PRF_N(3), .PRI_CYCLES(20), .TX_CYCLES(5), .RX_START(8), .RX_LEN(6)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .busy(busy), .tx_en(txEn), .rx_gate(rxGate), .rx_first(rxFirst), .rx_last(rxLast),
    .pulse_idx(pulseIdx), .cpi_start(cpiStart), .cpi_done(cpiDone), .aborted(aborted)
  );

  radar_timing_ctrl #(
    .PRF_N(1), .PRI_CYCLES(6), .TX_CYCLES(2), .RX_START(3), .RX_LEN(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(1'b0),
    .busy(busy1), .tx_en(txEn1), .rx_gate(rxGate1), .rx_first(rxFirst1), .rx_last(rxLast1),
    .pulse_idx(pulseIdx1), .cpi_start(cpiStart1), .cpi_done(cpiDone1), .aborted(aborted1)
  );

  assign obs  = {busy, txEn, rxGate, rxFirst, rxLast, cpiStart, cpiDone, aborted};
  assign obs1 = {busy1, txEn1, rxGate1, rxFirst1, rxLast1, cpiStart1, cpiDone1, aborted1};

  function automatic vec_t mk(int c, bit st, bit sp, logic [7:0] e, bit iv, int idx);
    vec_t v;
    v.cyc = c; v.st = st; v.sp = sp; v.exp = e; v.idxValid = iv; v.idx = idx;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Advance one clock; inputs set during the previous cycle are sampled on this edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cyc++;
    start  = 1'b0;
    stop   = 1'b0;
    start1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; start1 = 1'b0;

    // Single CPI with an ignored start, then start+stop in IDLE, abort in PRI 1, stop in IDLE.
    vecs.push_back(mk(  5, 0, 0, 8'b0000_0000, 1, 0));
    vecs.push_back(mk( 10, 1, 0, 8'b0000_0000, 1, 0));
    vecs.push_back(mk( 11, 0, 0, 8'b1100_0100, 1, 0));
    vecs.push_back(mk( 12, 0, 0, 8'b1100_0000, 1, 0));
    vecs.push_back(mk( 15, 0, 0, 8'b1100_0000, 1, 0));
    vecs.push_back(mk( 16, 0, 0, 8'b1000_0000, 1, 0));
    vecs.push_back(mk( 18, 0, 0, 8'b1000_0000, 1, 0));
    vecs.push_back(mk( 19, 0, 0, 8'b1011_0000, 1, 0));
    vecs.push_back(mk( 20, 0, 0, 8'b1010_0000, 1, 0));
    vecs.push_back(mk( 24, 0, 0, 8'b1010_1000, 1, 0));
    vecs.push_back(mk( 25, 0, 0, 8'b1000_0000, 1, 0));
    vecs.push_back(mk( 30, 1, 0, 8'b1000_0000, 1, 0));
    vecs.push_back(mk( 31, 0, 0, 8'b1100_0000, 1, 1));
    vecs.push_back(mk( 32, 0, 0, 8'b1100_0000, 1, 1));
    vecs.push_back(mk( 39, 0, 0, 8'b1011_0000, 1, 1));
    vecs.push_back(mk( 44, 0, 0, 8'b1010_1000, 1, 1));
    vecs.push_back(mk( 50, 0, 0, 8'b1000_0000, 1, 1));
    vecs.push_back(mk( 51, 0, 0, 8'b1100_0000, 1, 2));
    vecs.push_back(mk( 59, 0, 0, 8'b1011_0000, 1, 2));
    vecs.push_back(mk( 64, 0, 0, 8'b1010_1000, 1, 2));
    vecs.push_back(mk( 70, 0, 0, 8'b1000_0000, 1, 2));
    vecs.push_back(mk( 71, 0, 0, 8'b1000_0010, 0, 0));
    vecs.push_back(mk( 72, 1, 1, 8'b0000_0000, 1, 0));
    vecs.push_back(mk( 73, 0, 0, 8'b1100_0100, 1, 0));
    vecs.push_back(mk( 97, 0, 1, 8'b1100_0000, 1, 1));
    vecs.push_back(mk(105, 0, 0, 8'b1010_0000, 1, 1));
    vecs.push_back(mk(112, 0, 0, 8'b1000_0000, 1, 1));
    vecs.push_back(mk(113, 0, 0, 8'b1000_0001, 0, 0));
    vecs.push_back(mk(114, 0, 0, 8'b0000_0000, 1, 0));
    vecs.push_back(mk(133, 0, 0, 8'b0000_0000, 1, 0));
    vecs.push_back(mk(140, 0, 1, 8'b0000_0000, 1, 0));
    vecs.push_back(mk(141, 0, 0, 8'b0000_0000, 1, 0));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs", obs, 8'b0000_0000);
    checkValue("reset pulse_idx", int'(pulseIdx), 0);
    checkOutput("reset outputs dut1", obs1, 8'b0000_0000);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;

    foreach (vecs[i]) begin
      while (cyc < vecs[i].cyc) applyStimulus();
      checkOutput($sformatf("cycle %0d outputs", vecs[i].cyc), obs, vecs[i].exp);
      if (vecs[i].idxValid)
        checkValue($sformatf("cycle %0d pulse_idx", vecs[i].cyc), int'(pulseIdx), vecs[i].idx);
      start = vecs[i].st;
      stop  = vecs[i].sp;
    end

    // Reset mid-CPI, then a fresh CPI.
    while (cyc < 150) applyStimulus();
    start = 1'b1;
    while (cyc < 180) applyStimulus();
    checkOutput("pre-reset outputs", obs, 8'b1010_0000);
    checkValue("pre-reset pulse_idx", int'(pulseIdx), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset outputs", obs, 8'b0000_0000);
    checkValue("async reset pulse_idx", int'(pulseIdx), 0);
    while (cyc < 183) applyStimulus();
    checkOutput("held reset outputs", obs, 8'b0000_0000);
    #2 rst = 1'b0;
    while (cyc < 185) applyStimulus();
    checkOutput("idle after reset", obs, 8'b0000_0000);
    start = 1'b1;
    applyStimulus();
    checkOutput("restart cycle 186", obs, 8'b1100_0100);
    checkValue("restart pulse_idx", int'(pulseIdx), 0);
    while (cyc < 191) applyStimulus();
    checkOutput("restart cycle 191", obs, 8'b1000_0000);
    while (cyc < 196) applyStimulus();
    checkOutput("restart cycle 196", obs, 8'b1010_0000);
    checkValue("restart cycle 196 pulse_idx", int'(pulseIdx), 0);

    // Single-pulse CPI with RX_LEN=1: rx_first and rx_last coincide.
    while (cyc < 200) applyStimulus();
    start1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic [7:0] e;
      bit run;
      int cnt;
      applyStimulus();
      run = (k <= 6);
      cnt = k - 1;
      e = {k <= 7, run && cnt < 2, run && cnt == 3, run && cnt == 3, run && cnt == 3,
           k == 1, k == 7, 1'b0};
      checkOutput($sformatf("dut1 offset %0d", k), obs1, e);
      if (run) checkValue($sformatf("dut1 offset %0d pulse_idx", k), int'(pulseIdx1), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
